// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared types for the pipeline hazard controller
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MC_BUSY  = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_en;
        logic f_d_en;
        logic f_d_flush;
        logic d_e_en;
        logic d_e_flush;
    } hz_ctrl_t;

    // Flushed registers keep en=1; the flush takes precedence downstream.
    localparam hz_ctrl_t c_ctrl_run    = hz_ctrl_t'(5'b11010);
    localparam hz_ctrl_t c_ctrl_freeze = hz_ctrl_t'(5'b00000);
    localparam hz_ctrl_t c_ctrl_flush  = hz_ctrl_t'(5'b11111);
    localparam hz_ctrl_t c_ctrl_bubble = hz_ctrl_t'(5'b00011);

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// pipe_hazard_ctrl_if : decode/execute status in, pipeline-register controls out
// Optional counters present when HAZ_PERF_CNT_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = pipe_ctrl_pkg::REG_AW_DEF
);
    logic [REG_AW-1:0] d_rs1;
    logic [REG_AW-1:0] d_rs2;
    logic              d_rs1_use;
    logic              d_rs2_use;
    logic [REG_AW-1:0] e_rd;
    logic              e_is_load;
    logic              e_redirect;
    logic              e_mc_start;
    logic              e_mc_done;
    logic              pc_en;
    logic              f_d_en;
    logic              f_d_flush;
    logic              d_e_en;
    logic              d_e_flush;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
`endif

    modport master (
`ifdef HAZ_PERF_CNT_EN
        input  stall_cnt, flush_cnt,
`endif
        output d_rs1, d_rs2, d_rs1_use, d_rs2_use, e_rd, e_is_load,
               e_redirect, e_mc_start, e_mc_done,
        input  pc_en, f_d_en, f_d_flush, d_e_en, d_e_flush
    );

    modport slave (
`ifdef HAZ_PERF_CNT_EN
        output stall_cnt, flush_cnt,
`endif
        input  d_rs1, d_rs2, d_rs1_use, d_rs2_use, e_rd, e_is_load,
               e_redirect, e_mc_start, e_mc_done,
        output pc_en, f_d_en, f_d_flush, d_e_en, d_e_flush
    );

endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_lu_detect.sv
// ============================================================================
// hz_lu_detect : combinational load-use compare of D sources against E dest
// Rev 1.0
// ============================================================================
`default_nettype none

module hz_lu_detect #(
    parameter int REG_AW = 5
) (
    input  wire logic              i_e_is_load,
    input  wire logic [REG_AW-1:0] i_e_rd,
    input  wire logic [REG_AW-1:0] i_d_rs1,
    input  wire logic [REG_AW-1:0] i_d_rs2,
    input  wire logic              i_d_rs1_use,
    input  wire logic              i_d_rs2_use,
    output logic                   o_lu_hit
);

    logic w_rs1_match;
    logic w_rs2_match;

    always_comb begin
        w_rs1_match = i_d_rs1_use && (i_d_rs1 == i_e_rd);
        w_rs2_match = i_d_rs2_use && (i_d_rs2 == i_e_rd);
        // x0 is hardwired, so a load targeting it never creates a dependency
        o_lu_hit    = i_e_is_load && (i_e_rd != '0) && (w_rs1_match || w_rs2_match);
    end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/flush controller for PC, F/D and D/E registers
// Optional perf counters under HAZ_PERF_CNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int LU_BUBBLES = 2
) (
    input  wire logic        clk,
    input  wire logic        n_rst,
    pipe_hazard_ctrl_if.slave hz
);

    localparam logic [2:0] c_bub_init = 3'(LU_BUBBLES - 1);

    hz_state_e  r_state;
    logic [2:0] r_bub_cnt;
    logic       w_lu_hit;
    logic       w_freeze;
    logic       w_release;
    logic       w_redirect;
    logic       w_bubble;
    hz_ctrl_t   w_ctrl;

    hz_lu_detect #(
        .REG_AW (REG_AW)
    ) u_lu_detect (
        .i_e_is_load (hz.e_is_load),
        .i_e_rd      (hz.e_rd),
        .i_d_rs1     (hz.d_rs1),
        .i_d_rs2     (hz.d_rs2),
        .i_d_rs1_use (hz.d_rs1_use),
        .i_d_rs2_use (hz.d_rs2_use),
        .o_lu_hit    (w_lu_hit)
    );

    // Priority: MC freeze > redirect > load-use > normal
    always_comb begin
        w_freeze   = ((r_state == RUN && hz.e_mc_start) || r_state == MC_BUSY)
                     && !hz.e_mc_done;
        w_release  = (r_state == MC_BUSY) && hz.e_mc_done;
        w_redirect = !w_freeze && !w_release && hz.e_redirect;
        w_bubble   = !w_freeze && !w_release && !hz.e_redirect &&
                     ((r_state == LU_STALL) || (r_state == RUN && w_lu_hit));

        w_ctrl = c_ctrl_run;
        if (!n_rst)          w_ctrl = c_ctrl_freeze;
        else if (w_freeze)   w_ctrl = c_ctrl_freeze;
        else if (w_redirect) w_ctrl = c_ctrl_flush;
        else if (w_bubble)   w_ctrl = c_ctrl_bubble;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= RUN;
            r_bub_cnt <= 3'd0;
        end else if (w_freeze) begin
            r_state   <= MC_BUSY;
        end else if (w_release || w_redirect) begin
            r_state   <= RUN;
            r_bub_cnt <= 3'd0;
        end else if (w_bubble) begin
            if (r_state == LU_STALL) begin
                r_bub_cnt <= r_bub_cnt - 3'd1;
                if (r_bub_cnt == 3'd1) r_state <= RUN;
            end else if (LU_BUBBLES > 1) begin
                r_bub_cnt <= c_bub_init;
                r_state   <= LU_STALL;
            end
        end
    end

    assign hz.pc_en     = w_ctrl.pc_en;
    assign hz.f_d_en    = w_ctrl.f_d_en;
    assign hz.f_d_flush = w_ctrl.f_d_flush;
    assign hz.d_e_en    = w_ctrl.d_e_en;
    assign hz.d_e_flush = w_ctrl.d_e_flush;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (!w_ctrl.pc_en) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_redirect)    r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : directed scenarios plus random traffic vs. a bubble model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int c_aw  = 5;
    localparam int c_lub = 2;
    localparam logic [4:0] c_run    = 5'b11010;
    localparam logic [4:0] c_freeze = 5'b00000;
    localparam logic [4:0] c_flush  = 5'b11111;
    localparam logic [4:0] c_bubble = 5'b00011;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(c_aw)) hif ();

    pipe_hazard_ctrl #(
        .REG_AW     (c_aw),
        .LU_BUBBLES (c_lub)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .hz    (hif.slave)
    );

    logic [4:0] obs;
    assign obs = {hif.pc_en, hif.f_d_en, hif.f_d_flush, hif.d_e_en, hif.d_e_flush};

    // Reference: bubbles still owed and whether a multi-cycle op is outstanding
    int         m_bub, nx_bub;
    bit         m_mc, nx_mc, m_hit, exp_redir;
    logic [4:0] exp_ctrl;
    longint     m_stall, m_flush;

    always_comb begin
        exp_ctrl  = c_freeze;
        nx_bub    = m_bub;
        nx_mc     = m_mc;
        exp_redir = 1'b0;
        m_hit     = hif.e_is_load && (hif.e_rd != 0) &&
                    ((hif.d_rs1_use && hif.d_rs1 == hif.e_rd) ||
                     (hif.d_rs2_use && hif.d_rs2 == hif.e_rd));
        if (n_rst) begin
            if ((m_mc || (hif.e_mc_start && m_bub == 0)) && !hif.e_mc_done) begin
                exp_ctrl = c_freeze;
                nx_mc    = 1'b1;
            end else if (m_mc) begin
                exp_ctrl = c_run;
                nx_mc    = 1'b0;
            end else if (hif.e_redirect) begin
                exp_ctrl  = c_flush;
                nx_bub    = 0;
                exp_redir = 1'b1;
            end else if (m_bub > 0) begin
                exp_ctrl = c_bubble;
                nx_bub   = m_bub - 1;
            end else if (m_hit) begin
                exp_ctrl = c_bubble;
                nx_bub   = c_lub - 1;
            end else begin
                exp_ctrl = c_run;
            end
        end
    end

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_bub <= 0; m_mc <= 1'b0; m_stall <= 0; m_flush <= 0;
        end else begin
            m_bub <= nx_bub;
            m_mc  <= nx_mc;
            if (!exp_ctrl[4]) m_stall <= (m_stall + 1) % 64'h1_0000_0000;
            if (exp_redir)    m_flush <= (m_flush + 1) % 64'h1_0000_0000;
        end
    end

    task automatic set_in(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic ld,
                          input logic rdr, input logic st, input logic dn);
        hif.d_rs1 = rs1; hif.d_rs1_use = u1; hif.d_rs2 = rs2; hif.d_rs2_use = u2;
        hif.e_rd = rd; hif.e_is_load = ld; hif.e_redirect = rdr;
        hif.e_mc_start = st; hif.e_mc_done = dn;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) begin
            @(negedge clk); #1;
            checks++;
            if (obs !== c_freeze) begin
                errors++; $display("FAIL reset_outputs: got %b expected %b", obs, c_freeze);
            end
        end
        @(negedge clk); n_rst = 1'b1; #1;
        checks++;
        if (obs !== c_run) begin
            errors++; $display("FAIL reset_release: got %b expected %b", obs, c_run);
        end
    endtask

    task automatic test_load_use();
        logic [4:0] want [3] = '{c_bubble, c_bubble, c_run};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) set_in(5, 1, 0, 0, 5, 1, 0, 0, 0);
            else        set_in(5, 1, 0, 0, 0, 0, 0, 0, 0);
            #1; checks++;
            if (obs !== want[i]) begin
                errors++; $display("FAIL load_use_c%0d: got %b expected %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_no_stall();
        @(negedge clk); set_in(0, 1, 0, 0, 0, 1, 0, 0, 0); #1; checks++;
        if (obs !== c_run) begin
            errors++; $display("FAIL rd_zero: got %b expected %b", obs, c_run);
        end
        @(negedge clk); set_in(3, 1, 5, 0, 5, 1, 0, 0, 0); #1; checks++;
        if (obs !== c_run) begin
            errors++; $display("FAIL rs2_unused: got %b expected %b", obs, c_run);
        end
        @(negedge clk); set_in(3, 1, 5, 1, 5, 1, 0, 0, 0); #1; checks++;
        if (obs !== c_bubble) begin
            errors++; $display("FAIL rs2_hit: got %b expected %b", obs, c_bubble);
        end
        @(negedge clk); set_in(3, 1, 5, 1, 0, 0, 0, 0, 0); #1; checks++;
        if (obs !== c_bubble) begin
            errors++; $display("FAIL rs2_hit_b2: got %b expected %b", obs, c_bubble);
        end
    endtask

    task automatic test_mc();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_in(0, 0, 0, 0, 0, 0, 0, (i == 0), (i == 4)); #1; checks++;
            if (obs !== ((i < 4) ? c_freeze : c_run)) begin
                errors++;
                $display("FAIL mc_c%0d: got %b expected %b", i, obs, (i < 4) ? c_freeze : c_run);
            end
        end
    endtask

    task automatic test_redirect_abort();
        logic [4:0] want [3] = '{c_bubble, c_flush, c_run};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(7, 1, 0, 0, (i == 0) ? 5'd7 : 5'd0, (i == 0), (i == 1), 0, 0);
            #1; checks++;
            if (obs !== want[i]) begin
                errors++; $display("FAIL redirect_abort_c%0d: got %b expected %b", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_mc_vs_redirect();
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); #1; checks++;
        if (obs !== c_freeze) begin
            errors++; $display("FAIL mc_over_redirect: got %b expected %b", obs, c_freeze);
        end
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); #1; checks++;
        if (obs !== c_run) begin
            errors++; $display("FAIL mc_release: got %b expected %b", obs, c_run);
        end
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); #1; checks++;
        if (obs !== c_run) begin
            errors++; $display("FAIL mc_zero_stall: got %b expected %b", obs, c_run);
        end
    endtask

    task automatic test_reset_mid_mc();
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2; n_rst = 1'b0; hif.e_mc_done = 1'b1; #1; checks++;
        if (obs !== c_freeze) begin
            errors++; $display("FAIL reset_mid_mc: got %b expected %b", obs, c_freeze);
        end
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if (hif.stall_cnt !== 32'd0 || hif.flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL cnt_reset: got %0d/%0d expected 0/0", hif.stall_cnt, hif.flush_cnt);
        end
`endif
        @(negedge clk); n_rst = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1; checks++;
        if (obs !== c_run) begin
            errors++; $display("FAIL after_reset_run: got %b expected %b", obs, c_run);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            set_in(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                   1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0));
            #1; checks++;
            if (obs !== exp_ctrl) begin
                errors++; $display("FAIL random_c%0d: got %b expected %b", i, obs, exp_ctrl);
            end
        end
`ifdef HAZ_PERF_CNT_EN
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1; checks++;
        if (hif.stall_cnt !== 32'(m_stall) || hif.flush_cnt !== 32'(m_flush)) begin
            errors++;
            $display("FAIL perf_cnt: got %0d/%0d expected %0d/%0d",
                     hif.stall_cnt, hif.flush_cnt, m_stall, m_flush);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_mc();
        test_redirect_abort();
        test_mc_vs_redirect();
        test_reset_mid_mc();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
